// File: rtl/binary_mul_pkg.sv
// Shared constants and types for consumers of the 7x7 pipelined multiplier.
package binary_mul_pkg;

  localparam int MUL_P_W     = 14;
  localparam int MUL_LATENCY = 8;
  localparam int MUL_LEN_W   = 8;
  // Batch counter only ever needs to reach the programmed length.
  localparam int MUL_CNT_W   = MUL_LEN_W;

  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_t;

endpackage

// File: rtl/binary_mul_vld_pipe.sv
// Enabled valid delay line: vld_o is vld_i delayed LATENCY enabled clocks.
module binary_mul_vld_pipe #(
  parameter int LATENCY = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic vld_i,
  output logic vld_o
);

  logic [LATENCY-1:0] pipe_q;

  generate
    if (LATENCY == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  pipe_q <= '0;
        else if (en) pipe_q <= vld_i;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  pipe_q <= '0;
        else if (en) pipe_q <= {pipe_q[LATENCY-2:0], vld_i};
      end
    end
  endgenerate

  assign vld_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/binary_mul_acc_uni.sv
// Batch accumulator for multiplier products; re-times the issue strobe to tag p_in.
// Define BINARY_MUL_ACC_SAT_EN to saturate the sum on overflow instead of wrapping.
module binary_mul_acc_uni
  import binary_mul_pkg::*;
#(
  parameter int P_W     = MUL_P_W,
  parameter int ACC_W   = 24,
  parameter int LATENCY = MUL_LATENCY,
  parameter int LEN_W   = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             issue,
  input  logic [P_W-1:0]   p_in,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             busy,
  output logic             overflow,
  output logic             drop_err
);

  acc_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W:0]   sum_ext;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic             vld_q, vld_d;
  logic             tag;

  binary_mul_vld_pipe #(.LATENCY(LATENCY)) u_vld_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .vld_i (issue),
    .vld_o (tag)
  );

  assign sum_ext = {1'b0, sum_q} + (ACC_W+1)'(p_in);
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    vld_d   = 1'b0;
    if (en) begin
      // Start wins over a same-cycle tag: that product is discarded silently.
      if (start) begin
        len_d = len;
        cnt_d = '0;
        sum_d = '0;
        ovf_d = 1'b0;
        if (len == '0) begin
          state_d = DONE;
          vld_d   = 1'b1;
        end else begin
          state_d = ACC;
        end
      end else if (tag) begin
        if (state_q == ACC) begin
          ovf_d = ovf_q | sum_ext[ACC_W];
`ifdef BINARY_MUL_ACC_SAT_EN
          sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
          sum_d = sum_ext[ACC_W-1:0];
`endif
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = DONE;
            vld_d   = 1'b1;
          end
        end else begin
          drop_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      vld_q   <= vld_d;
    end
  end

  // A pulse landing in a disabled cycle is lost, not deferred.
  assign acc_valid = vld_q & en;
  assign acc_out   = sum_q;
  assign busy      = (state_q == ACC);
  assign overflow  = ovf_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_binary_mul_acc_uni.sv
// Bench for binary_mul_acc_uni: 24-bit and 16-bit accumulators driven in parallel.
module tb_binary_mul_acc_uni;

  localparam int L = 8;
`ifdef BINARY_MUL_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk, rst_n, en, issue, start;
  logic [13:0] p_in;
  logic [7:0]  len;
  logic [23:0] acc24;
  logic [15:0] acc16;
  logic        v24, b24, o24, d24, v16, b16, o16, d16;

  binary_mul_acc_uni #(.ACC_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .issue(issue), .p_in(p_in),
    .start(start), .len(len), .acc_out(acc24), .acc_valid(v24),
    .busy(b24), .overflow(o24), .drop_err(d24));

  binary_mul_acc_uni #(.ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .issue(issue), .p_in(p_in),
    .start(start), .len(len), .acc_out(acc16), .acc_valid(v16),
    .busy(b16), .overflow(o16), .drop_err(d16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests, n_fail;
  // Issue history: element 0 is the issue whose product is on p_in now.
  bit q_iss[$];
  int q_prod[$];
  // Spec-level batch model: 0 idle, 1 accumulating, 2 done.
  int m_st, m_len, m_cnt, m_s24, m_s16;
  bit m_o24, m_o16, m_drop, m_vld;
  bit obs_vld, obs_o16;
  int obs24, obs16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int add_w(input int s, input int p, input int w, output bit carry);
    int lim, r;
    lim   = 1 << w;
    r     = s + p;
    carry = (r >= lim);
    if (carry) r = SAT ? lim - 1 : r - lim;
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_len = 0; m_cnt = 0; m_s24 = 0; m_s16 = 0;
    m_o24 = 0; m_o16 = 0; m_drop = 0; m_vld = 0;
    q_iss.delete(); q_prod.delete();
    for (int i = 0; i < L; i++) begin q_iss.push_back(1'b0); q_prod.push_back(0); end
  endtask

  // One clock: drive, check at negedge, advance model, return at posedge+1.
  task automatic cyc(input bit e, input bit iss, input int a, input int b,
                     input bit st, input int ln);
    bit tag, nv, c24, c16;
    int prod;
    en = e; issue = iss; start = st; len = 8'(ln);
    tag  = q_iss[0];
    prod = q_prod[0];
    p_in = tag ? 14'(prod) : 14'($urandom);
    @(negedge clk);
    chk("acc_out",      32'(acc24), m_s24);
    chk("acc_out_w16",  32'(acc16), m_s16);
    chk("acc_valid",    32'(v24),   32'(m_vld & e));
    chk("acc_valid_w16",32'(v16),   32'(m_vld & e));
    chk("busy",         32'(b24),   32'(m_st == 1));
    chk("busy_w16",     32'(b16),   32'(m_st == 1));
    chk("overflow",     32'(o24),   32'(m_o24));
    chk("overflow_w16", 32'(o16),   32'(m_o16));
    chk("drop_err",     32'(d24),   32'(m_drop));
    chk("drop_err_w16", 32'(d16),   32'(m_drop));
    obs_vld = v24; obs24 = int'(acc24); obs16 = int'(acc16); obs_o16 = o16;
    if (e) begin
      nv = 1'b0;
      if (st) begin
        m_len = ln; m_cnt = 0; m_s24 = 0; m_s16 = 0; m_o24 = 0; m_o16 = 0;
        if (ln == 0) begin m_st = 2; nv = 1'b1; end
        else m_st = 1;
      end else if (tag) begin
        if (m_st == 1) begin
          m_s24 = add_w(m_s24, prod, 24, c24); m_o24 |= c24;
          m_s16 = add_w(m_s16, prod, 16, c16); m_o16 |= c16;
          m_cnt++;
          if (m_cnt == m_len) begin m_st = 2; nv = 1'b1; end
        end else begin
          m_drop = 1'b1;
        end
      end
      m_vld = nv;
      q_iss.delete(0); q_prod.delete(0);
      q_iss.push_back(iss); q_prod.push_back(a * b);
    end else begin
      m_vld = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_valid(input int maxc, output int n, output bit got);
    got = 1'b0; n = 0;
    while (!got && n < maxc) begin
      cyc(1, 0, 0, 0, 0, 0);
      n++;
      got = obs_vld;
    end
  endtask

  typedef struct {
    int len; int a; int b; int n_iss;
    int exp24; int exp16; bit ovf16; int lat;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int n, acc_before;
    bit got;
    n_tests = 0; n_fail = 0;

    tbl[0] = '{len:1, a:3,   b:5,   n_iss:1, exp24:15,    exp16:15,    ovf16:0, lat:9};
    tbl[1] = '{len:4, a:127, b:127, n_iss:4, exp24:64516, exp16:64516, ovf16:0, lat:9};
    tbl[2] = '{len:5, a:127, b:127, n_iss:5, exp24:80645, exp16:(SAT ? 65535 : 15109), ovf16:1, lat:9};
    tbl[3] = '{len:0, a:0,   b:0,   n_iss:0, exp24:0,     exp16:0,     ovf16:0, lat:1};
    tbl[4] = '{len:3, a:0,   b:99,  n_iss:3, exp24:0,     exp16:0,     ovf16:0, lat:9};
    tbl[5] = '{len:2, a:100, b:50,  n_iss:2, exp24:10000, exp16:10000, ovf16:0, lat:9};

    rst_n = 1'b1; en = 1'b0; issue = 1'b0; start = 1'b0; len = '0; p_in = '0;
    #3 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_acc_out",   32'(acc24), 0);
    chk("reset_acc_valid", 32'(v24),   0);
    chk("reset_busy",      32'(b24),   0);
    chk("reset_overflow",  32'(o24),   0);
    chk("reset_drop_err",  32'(d24),   0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of complete batches: start, back-to-back issues, then await the pulse.
    for (int t = 0; t < 6; t++) begin
      cyc(1, 0, 0, 0, 1, tbl[t].len);
      for (int k = 0; k < tbl[t].n_iss; k++) cyc(1, 1, tbl[t].a, tbl[t].b, 0, 0);
      wait_valid(30, n, got);
      chk("tbl_valid_seen", 32'(got), 1);
      chk("tbl_latency",    n,        tbl[t].lat);
      chk("tbl_acc24",      obs24,    tbl[t].exp24);
      chk("tbl_acc16",      obs16,    tbl[t].exp16);
      chk("tbl_ovf16",      32'(obs_o16), 32'(tbl[t].ovf16));
      idle(2);
    end

    // en gap of 3 cycles mid-stream shifts completion by exactly 3.
    cyc(1, 0, 0, 0, 1, 4);
    cyc(1, 1, 127, 127, 0, 0);
    cyc(1, 1, 127, 127, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 127, 127, 0, 0);
    cyc(1, 1, 127, 127, 0, 0);
    wait_valid(30, n, got);
    chk("gap_valid_seen", 32'(got), 1);
    chk("gap_done_cycle", 7 + n, 16);
    chk("gap_acc",        obs24, 64516);
    idle(2);

    // en low exactly when the pulse is due: it is dropped, not deferred.
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 1, 6, 7, 0, 0);
    idle(8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("en_low_pulse_suppressed", 32'(obs_vld), 0);
    wait_valid(4, n, got);
    chk("en_low_no_late_pulse", 32'(got), 0);
    chk("en_low_acc", obs24, 42);

    // Restart mid-batch: old tag in the restart cycle is dropped, later ones count.
    cyc(1, 0, 0, 0, 1, 3);
    cyc(1, 1, 10, 10, 0, 0);
    cyc(1, 1, 10, 10, 0, 0);
    idle(6);
    cyc(1, 0, 0, 0, 1, 2);
    cyc(1, 1, 7, 7, 0, 0);
    wait_valid(30, n, got);
    chk("restart_valid_seen", 32'(got), 1);
    chk("restart_latency",    n, 9);
    chk("restart_acc",        obs24, 149);
    chk("restart_no_drop",    32'(d24), 0);
    idle(2);

    // Issue with no batch active.
    acc_before = int'(acc24);
    cyc(1, 1, 9, 9, 0, 0);
    idle(10);
    chk("drop_err_set",       32'(d24), 1);
    chk("drop_acc_unchanged", 32'(acc24), acc_before);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 127),
          $urandom_range(0, 127), $urandom_range(0, 15) == 0, $urandom_range(0, 6));
    end
    idle(12);

    // Asynchronous reset partway through a len=4 batch.
    cyc(1, 0, 0, 0, 1, 4);
    for (int k = 0; k < 4; k++) cyc(1, 1, 127, 127, 0, 0);
    idle(3);
    #2 rst_n = 1'b0; en = 1'b0; issue = 1'b0; start = 1'b0;
    #1;
    chk("midrst_acc_out",   32'(acc24), 0);
    chk("midrst_acc_valid", 32'(v24),   0);
    chk("midrst_busy",      32'(b24),   0);
    chk("midrst_overflow",  32'(o24),   0);
    chk("midrst_drop_err",  32'(d24),   0);
    chk("midrst_acc_w16",   32'(acc16), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 1, 127, 127, 0, 0);
    idle(10);
    chk("postrst_drop_err", 32'(d24),   1);
    chk("postrst_acc_out",  32'(acc24), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
